// File: rtl/key_cond_pkg.sv
// Shared types and width helpers for the push-button conditioner.
package key_cond_pkg;

    typedef enum logic [2:0] {
        REL,
        PRESS_CHK,
        HELD,
        LONG_HELD,
        REL_CHK
    } key_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button channel: two-flop synchroniser, debounce FSM and hold timer.
module key_channel
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned LONG_CYCLES     = 12000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [1:0]        sync_q;
    logic              sample;
    key_state_e        state_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              was_long_q;

    assign sample = sync_q[1] ^ ACTIVE_LOW;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q     <= {2{ACTIVE_LOW}};
            state_q    <= REL;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            was_long_q <= 1'b0;
            o_level    <= 1'b0;
            o_press    <= 1'b0;
            o_release  <= 1'b0;
            o_long     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], i_key_raw};
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;

            unique case (state_q)
                REL: begin
                    if (sample) begin
                        state_q  <= PRESS_CHK;
                        db_cnt_q <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!sample) begin
                        state_q  <= REL;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q    <= HELD;
                        db_cnt_q   <= '0;
                        hold_cnt_q <= '0;
                        o_level    <= 1'b1;
                        o_press    <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!sample) begin
                        state_q    <= REL_CHK;
                        db_cnt_q   <= '0;
                        was_long_q <= 1'b0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q <= LONG_HELD;
                        o_long  <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                LONG_HELD: begin
                    // hold_cnt_q stays at HOLD_LAST so the long pulse cannot repeat.
                    if (!sample) begin
                        state_q    <= REL_CHK;
                        db_cnt_q   <= '0;
                        was_long_q <= 1'b1;
                    end
                end
                REL_CHK: begin
                    if (sample) begin
                        state_q  <= was_long_q ? LONG_HELD : HELD;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q    <= REL;
                        db_cnt_q   <= '0;
                        hold_cnt_q <= '0;
                        o_level    <= 1'b0;
                        o_release  <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                default: begin
                    state_q  <= REL;
                    db_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions the start/pause/stop buttons into clean levels and single-cycle pulses.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned LONG_CYCLES     = 12000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_KEYS-1:0] i_key_raw,
    output logic [NUM_KEYS-1:0] o_level,
    output logic [NUM_KEYS-1:0] o_press,
    output logic [NUM_KEYS-1:0] o_release,
    output logic [NUM_KEYS-1:0] o_long,
    output logic                o_any_press
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_key_channel (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_key_raw(i_key_raw[g]),
            .o_level  (o_level[g]),
            .o_press  (o_press[g]),
            .o_release(o_release[g]),
            .o_long   (o_long[g])
        );
    end

    assign o_any_press = |o_press;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce and long-press windows.
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] raw;
    logic [2:0] level, press, release_p, long_p;
    logic       any_press;

    always #5 clk = ~clk;

    key_conditioner #(
        .NUM_KEYS       (3),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_key_raw  (raw),
        .o_level    (level),
        .o_press    (press),
        .o_release  (release_p),
        .o_long     (long_p),
        .o_any_press(any_press)
    );

    int   t = 0;
    logic rst_smp = 1'b1;

    // Edge counter: cycle t is the interval following the t-th rising edge.
    always @(posedge clk) begin
        t = t + 1;
        rst_smp = rst;
    end

    int         n_vec = 0;
    int         n_err = 0;
    int         p_at[3];
    int         r_at[3];
    int         l_at[3];
    logic [2:0] lvl_e = 3'b000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic clear_sched();
        for (int b = 0; b < 3; b++) begin
            p_at[b] = -1;
            r_at[b] = -1;
            l_at[b] = -1;
        end
    endtask

    task automatic tick(input int n);
        logic [2:0] pe, re, le;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pe = 3'b000;
            re = 3'b000;
            le = 3'b000;
            if (rst_smp) begin
                lvl_e = 3'b000;
            end else begin
                for (int b = 0; b < 3; b++) begin
                    if (t == p_at[b]) begin
                        pe[b]    = 1'b1;
                        lvl_e[b] = 1'b1;
                    end
                    if (t == r_at[b]) begin
                        re[b]    = 1'b1;
                        lvl_e[b] = 1'b0;
                    end
                    if (t == l_at[b]) le[b] = 1'b1;
                end
            end
            check_eq("press",   32'(press),     32'(pe));
            check_eq("release", 32'(release_p), 32'(re));
            check_eq("long",    32'(long_p),    32'(le));
            check_eq("level",   32'(level),     32'(lvl_e));
            check_eq("any",     32'(any_press), 32'(|pe));
        end
    endtask

    int pt;

    initial begin
        clear_sched();
        rst = 1'b1;
        raw = 3'b111;
        tick(3);
        rst = 1'b0;

        // 1: idle keys produce nothing
        tick(30);

        // 2: key0 press, long press, then release from LONG_HELD
        raw[0]  = 1'b0;
        p_at[0] = t + 7;
        l_at[0] = t + 27;
        tick(30);
        raw[0]  = 1'b1;
        r_at[0] = t + 7;
        tick(10);

        // 3: key1 bounce 0,1,0,1 then stable 0
        raw[1] = 1'b0; tick(1);
        raw[1] = 1'b1; tick(1);
        raw[1] = 1'b0; tick(1);
        raw[1] = 1'b1; tick(1);
        raw[1]  = 1'b0;
        p_at[1] = t + 7;
        tick(12);
        raw[1]  = 1'b1;
        r_at[1] = t + 7;
        tick(10);

        // 4: simultaneous key0 + key2 press
        raw[0]  = 1'b0;
        raw[2]  = 1'b0;
        pt      = t + 7;
        p_at[0] = pt;
        p_at[2] = pt;
        l_at[2] = pt + 20;
        tick(8);

        // 5: glitch on key0 during hold is absorbed, then a short-hold release
        raw[0] = 1'b1; tick(1);
        raw[0] = 1'b0; tick(6);
        raw[0]  = 1'b1;
        r_at[0] = t + 7;
        tick(16);

        // 6: reset while key2 sits in LONG_HELD
        clear_sched();
        rst = 1'b1;
        tick(1);
        rst     = 1'b0;
        p_at[2] = t + 7;
        tick(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
